// File: rtl/ring_counter_multi.sv
// ring_counter_multi: parametrised ring/Johnson sequence generator with load, self-correction and terminal-count pulse
module ring_counter_multi #(
    parameter int WIDTH = 4,
    parameter logic [WIDTH-1:0] RING_SEED = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             err
);
    function automatic logic legal(input logic [WIDTH-1:0] v, input logic m);
        legal = m ? ($countones((v ^ (v >> 1)) & {1'b0, {(WIDTH-1){1'b1}}}) <= 1)
                  : ($countones(v) == 1);
    endfunction

    logic [WIDTH-1:0] seed, shifted, nxt;
    logic             ok_out, ok_load, tc_n, err_n;

    // Johnson feedback is the inverted bit wrapping around
    always_comb begin
        seed    = mode ? '0 : RING_SEED;
        ok_out  = legal(out, mode);
        ok_load = legal(load_val, mode);
        shifted = dir ? {mode ? ~out[0] : out[0], out[WIDTH-1:1]}
                      : {out[WIDTH-2:0], mode ? ~out[WIDTH-1] : out[WIDTH-1]};
        nxt     = load ? (ok_load ? load_val : seed) : en ? (ok_out ? shifted : seed) : out;
        tc_n    = !load && en && ok_out && (shifted == seed);
        err_n   = load ? !ok_load : (en && !ok_out);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out <= seed;
            tc  <= 1'b0;
            err <= 1'b0;
        end else begin
            out <= nxt;
            tc  <= tc_n;
            err <= err_n;
        end
    end
endmodule
